rd_arbiter: RTL
===============

RD_ARBITER -- requirements
Module: rd_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 4: beats per line burst, legal range 2..16.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 inst_rd_req  in  1  fetch-side line read request, held until granted.
REQ-005 inst_rd_addr  in  32  fetch read address, line-aligned.
REQ-006 data_rd_req  in  1  load-side read request, held until granted.
REQ-007 data_rd_addr  in  32  load read address.
REQ-008 data_rd_burst  in  1  1 = line burst of LINE_WORDS beats, 0 = single word.
REQ-009 inst_rd_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-010 data_rd_gnt  out  1  one-cycle pulse: load request accepted.
REQ-011 rd_rdata  out  32  returned beat, shared by both requesters.
REQ-012 inst_rd_rvalid  out  1  rd_rdata belongs to fetch.
REQ-013 data_rd_rvalid  out  1  rd_rdata belongs to load.
REQ-014 rd_last  out  1  final beat of current transfer.
REQ-015 rd_err  out  1  sticky: beat count and rlast disagreed.
REQ-016 stallreq_axi  out  1  pipeline stall request to the pipeline controller.
REQ-017 araddr  out  32  AXI read address.
REQ-018 arlen  out  8  AXI burst length minus one.
REQ-019 arvalid  out  1  AXI address valid.
REQ-020 arready  in  1  AXI address ready.
REQ-021 rdata  in  32  AXI read data.
REQ-022 rlast  in  1  AXI last beat.
REQ-023 rvalid  in  1  AXI data valid.
REQ-024 rready  out  1  AXI data ready.

Function
REQ-025 FSM states IDLE, ADDR, DATA; one transfer outstanding at most.
REQ-026 IDLE: when any request is pending, pick winner, pulse its gnt the same cycle, register araddr/arlen/owner, go ADDR next cycle.
REQ-027 Arbitration: data wins over inst when both are pending.
REQ-028 arlen = LINE_WORDS-1 for inst and for data with burst=1; arlen = 0 for data with burst=0.
REQ-029 ADDR: arvalid=1 with araddr/arlen stable; on arvalid&arready go DATA; arvalid never drops before arready.
REQ-030 DATA: rready=1; each rvalid beat drives rd_rdata=rdata, raises the owner's rvalid only, and increments a beat counter.
REQ-031 rd_last = rvalid&rlast in DATA; on that beat return to IDLE; a new grant is possible the following cycle.
REQ-032 rd_err sets when rlast arrives on a beat other than arlen, or beat arlen arrives without rlast; transfer still ends on rlast.
REQ-033 stallreq_axi = 1 when FSM is in ADDR or DATA, or in IDLE with a request pending that is not granted that cycle; otherwise 0.
REQ-034 Requests arriving while busy are held by requesters; no internal queue.
REQ-035 Deasserting a request before its gnt is legal and cancels it.

Reset
REQ-036 Reset: state IDLE, counter 0, arvalid/rready/gnts/rvalids/rd_last/rd_err/stallreq_axi 0, araddr/arlen 0.
REQ-037 Reset mid-burst: abandon transfer immediately; remaining AXI beats after reset are not forwarded.

Configuration
REQ-038 RD_ARB_RR_EN defined: round-robin; on a tie, the requester not granted last wins; last-winner flag resets to data.
REQ-039 RD_ARB_RR_EN undefined: fixed data priority per REQ-027.

Verification
REQ-040 inst_rd_req, addr 0x1C000000, arready after 2 cycles -> inst_rd_gnt one cycle, arlen=3, 4 inst_rd_rvalid beats, rd_last on 4th, stallreq_axi 0 in the cycle after the last beat.
REQ-041 Both requests in same IDLE cycle, fixed priority -> data_rd_gnt first, inst_rd_gnt the cycle after the data last beat.
REQ-042 With RD_ARB_RR_EN, both requests held for two transfers -> grant order data, inst, data.
REQ-043 data_rd_burst=0, addr 0x80 -> arlen=0, single beat with rd_last=1, rd_err stays 0.
REQ-044 rlast on beat 2 of a 4-beat burst -> rd_err=1, FSM back to IDLE; rd_err stays 1 until reset.
REQ-045 reset asserted during DATA beat 1 -> all outputs 0 the next cycle; later rvalid beats do not raise any rvalid output.

Source files
------------

// File: rtl/rd_arbiter.sv
// Read-channel arbiter: shares one AXI read port between fetch (line) and load requesters.
// Optional macro RD_ARB_RR_EN selects round-robin on ties; default is fixed data priority.
module rd_arbiter #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_rd_req,
  input  logic [31:0] inst_rd_addr,
  input  logic        data_rd_req,
  input  logic [31:0] data_rd_addr,
  input  logic        data_rd_burst,
  output logic        inst_rd_gnt,
  output logic        data_rd_gnt,
  output logic [31:0] rd_rdata,
  output logic        inst_rd_rvalid,
  output logic        data_rd_rvalid,
  output logic        rd_last,
  output logic        rd_err,
  output logic        stallreq_axi,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;   // 1 = load side owns the transfer
  logic        err_q, err_d;
  logic        any_req, pick_data, win;

  assign any_req = inst_rd_req | data_rd_req;
  assign win     = (state_q == S_IDLE) & any_req;

`ifdef RD_ARB_RR_EN
  logic last_data_q, hist_q;

  // Until the first grant there is no "last winner" to rotate away from, so data wins the first tie.
  assign pick_data = data_rd_req & (~inst_rd_req | ~hist_q | ~last_data_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_data_q <= 1'b1;
      hist_q      <= 1'b0;
    end else if (win) begin
      last_data_q <= pick_data;
      hist_q      <= 1'b1;
    end
  end
`else
  assign pick_data = data_rd_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_ADDR;
      S_ADDR:  if (arready) state_d = S_DATA;
      S_DATA:  if (rvalid && rlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (win) begin
      owner_d  = pick_data;
      araddr_d = pick_data ? data_rd_addr : inst_rd_addr;
      arlen_d  = (pick_data && !data_rd_burst) ? 8'd0 : LINE_LEN;
      cnt_d    = '0;
    end
    if (state_q == S_DATA && rvalid) begin
      cnt_d = rlast ? 8'd0 : cnt_q + 8'd1;
      if (rlast != (cnt_q == arlen_q)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      araddr_q <= '0;
      arlen_q  <= '0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Combinational outputs are held low during reset so an abandoned burst is never forwarded.
  always_comb begin
    inst_rd_gnt    = 1'b0;
    data_rd_gnt    = 1'b0;
    rd_rdata       = '0;
    inst_rd_rvalid = 1'b0;
    data_rd_rvalid = 1'b0;
    rd_last        = 1'b0;
    stallreq_axi   = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          data_rd_gnt  = pick_data;
          inst_rd_gnt  = inst_rd_req & ~pick_data;
          stallreq_axi = any_req & ~(data_rd_gnt | inst_rd_gnt);
        end
        S_ADDR: begin
          arvalid      = 1'b1;
          stallreq_axi = 1'b1;
        end
        S_DATA: begin
          rready       = 1'b1;
          stallreq_axi = 1'b1;
          if (rvalid) begin
            rd_rdata       = rdata;
            data_rd_rvalid = owner_q;
            inst_rd_rvalid = ~owner_q;
            rd_last        = rlast;
          end
        end
        default: ;
      endcase
    end
  end

  assign araddr = araddr_q;
  assign arlen  = arlen_q;
  assign rd_err = err_q;

endmodule
